// File: rtl/btn_click_decoder.sv
// Classifies debounced button pulses into single/double/triple clicks using an
// inter-click window, and applies each click's action to the capture mode
// selector and the arm flag.
//
// state | meaning
// IDLE  | no window open
// C1    | one press seen, window open
// C2    | two presses seen, window open
// C3    | three or more presses seen, window open
module btn_click_decoder #(
  parameter logic [23:0] WIN_MAX  = 24'd9_999_999,
  parameter int          MODE_NUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_flag,
  output logic       click_single,
  output logic       click_double,
  output logic       click_triple,
  output logic [1:0] click_cnt,
  output logic       busy,
  output logic [1:0] mode,
  output logic       armed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C1   = 2'd1,
    C2   = 2'd2,
    C3   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LAST = 2'(MODE_NUM - 1);

  state_t      state_q, state_d;
  logic [23:0] win_cnt_q, win_cnt_d;
  logic        single_q, single_d;
  logic        double_q, double_d;
  logic        triple_q, triple_d;
  logic [1:0]  mode_q, mode_d;
  logic        armed_q, armed_d;

  // State, window counter, event pulses and user-visible settings all
  // register here; a press in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      triple_q  <= 1'b0;
      mode_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      single_q  <= single_d;
      double_q  <= double_d;
      triple_q  <= triple_d;
      mode_q    <= mode_d;
      armed_q   <= armed_d;
    end
  end

  // Press counting, window timing and event/action decode. A press on the
  // window's last cycle takes priority, so the burst is extended, not closed.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    single_d  = 1'b0;
    double_d  = 1'b0;
    triple_d  = 1'b0;
    mode_d    = mode_q;
    armed_d   = armed_q;

    if (state_q == IDLE) begin
      if (btn_flag) begin
        state_d   = C1;
        win_cnt_d = '0;
      end
    end else if (btn_flag) begin
      win_cnt_d = '0;
      case (state_q)
        C1:      state_d = C2;
        default: state_d = C3;
      endcase
    end else if (win_cnt_q == WIN_MAX) begin
      state_d   = IDLE;
      win_cnt_d = '0;
      case (state_q)
        C1: begin
          single_d = 1'b1;
          mode_d   = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
        end
        C2: begin
          double_d = 1'b1;
          armed_d  = ~armed_q;
        end
        default: begin
          triple_d = 1'b1;
          mode_d   = 2'd0;
          armed_d  = 1'b0;
        end
      endcase
    end else begin
      win_cnt_d = win_cnt_q + 24'd1;
    end
  end

  assign click_single = single_q;
  assign click_double = double_q;
  assign click_triple = triple_q;
  assign click_cnt    = state_q;
  assign busy         = (state_q != IDLE);
  assign mode         = mode_q;
  assign armed        = armed_q;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Directed bench for btn_click_decoder with a 20-cycle window (WIN_MAX = 19).
module tb_btn_click_decoder;

  logic       clk;
  logic       rst;
  logic       btn_flag;
  logic       click_single;
  logic       click_double;
  logic       click_triple;
  logic [1:0] click_cnt;
  logic       busy;
  logic [1:0] mode;
  logic       armed;

  int n_cmp;
  int n_err;

  btn_click_decoder #(
    .WIN_MAX (24'd19),
    .MODE_NUM(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_flag    (btn_flag),
    .click_single(click_single),
    .click_double(click_double),
    .click_triple(click_triple),
    .click_cnt   (click_cnt),
    .busy        (busy),
    .mode        (mode),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view: {single, double, triple, cnt[1:0], busy, mode[1:0], armed}
  typedef struct {
    logic       rst;
    logic       btn;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock edge with the given inputs; outputs sampled 1 time unit later
  task automatic tick(input logic r, input logic b);
    rst      = r;
    btn_flag = b;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    btn_flag = 1'b0;
  endtask

  // n idle edges; event pattern {s,d,t} expected only after idle edge 'at'
  task automatic idle_check(input string name, input int n, input int at, input logic [2:0] ev);
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, 1'b0);
      chk(name, {29'd0, click_single, click_double, click_triple}, (i == at) ? {29'd0, ev} : 32'd0);
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] c, input logic b,
                           input logic [1:0] m, input logic a);
    chk(name, {26'd0, click_cnt, busy, mode, armed}, {26'd0, c, b, m, a});
  endtask

  initial begin
    logic [1:0] wrap_exp[3];
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    btn_flag = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 9'b000_00_0_00_0};
    vecs[1]  = '{1'b1, 1'b1, 9'b000_00_0_00_0};
    vecs[2]  = '{1'b1, 1'b0, 9'b000_00_0_00_0};
    vecs[3]  = '{1'b0, 1'b0, 9'b000_00_0_00_0};
    vecs[4]  = '{1'b0, 1'b1, 9'b000_01_1_00_0};
    vecs[5]  = '{1'b0, 1'b0, 9'b000_01_1_00_0};
    vecs[6]  = '{1'b0, 1'b1, 9'b000_10_1_00_0};
    vecs[7]  = '{1'b0, 1'b1, 9'b000_11_1_00_0};
    vecs[8]  = '{1'b0, 1'b1, 9'b000_11_1_00_0};
    vecs[9]  = '{1'b1, 1'b1, 9'b000_00_0_00_0};
    vecs[10] = '{1'b0, 1'b0, 9'b000_00_0_00_0};
    vecs[11] = '{1'b0, 1'b1, 9'b000_01_1_00_0};
    vecs[12] = '{1'b1, 1'b0, 9'b000_00_0_00_0};

    for (int v = 0; v < 13; v++) begin
      tick(vecs[v].rst, vecs[v].btn);
      chk($sformatf("vec%0d", v),
          {23'd0, click_single, click_double, click_triple, click_cnt, busy, mode, armed},
          {23'd0, vecs[v].exp});
    end

    // reset released: nothing happens without presses
    idle_check("quiet_after_reset", 30, 0, 3'b000);

    // single click: event after edge t+20, mode 0 -> 1
    tick(1'b0, 1'b1);
    chk_state("single_open", 2'd1, 1'b1, 2'd0, 1'b0);
    idle_check("single_evt", 19, 0, 3'b000);
    chk_state("single_busy_late", 2'd1, 1'b1, 2'd0, 1'b0);
    idle_check("single_evt", 6, 1, 3'b100);
    chk_state("single_done", 2'd0, 1'b0, 2'd1, 1'b0);

    // three more singles 40 cycles apart: mode 2, 3, 0
    wrap_exp[0] = 2'd2;
    wrap_exp[1] = 2'd3;
    wrap_exp[2] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1);
      idle_check("wrap_evt", 39, 20, 3'b100);
      chk_state("wrap_mode", 2'd0, 1'b0, wrap_exp[k], 1'b0);
    end

    // double click, presses 5 apart: toggles armed
    tick(1'b0, 1'b1);
    idle_check("dbl_gap", 4, 0, 3'b000);
    tick(1'b0, 1'b1);
    chk_state("dbl_cnt", 2'd2, 1'b1, 2'd0, 1'b0);
    idle_check("dbl_evt", 25, 20, 3'b010);
    chk_state("dbl_done", 2'd0, 1'b0, 2'd0, 1'b1);

    // presses exactly 20 edges apart: same burst
    tick(1'b0, 1'b1);
    idle_check("bnd20_gap", 19, 0, 3'b000);
    tick(1'b0, 1'b1);
    chk_state("bnd20_cnt", 2'd2, 1'b1, 2'd0, 1'b1);
    idle_check("bnd20_evt", 25, 20, 3'b010);
    chk_state("bnd20_done", 2'd0, 1'b0, 2'd0, 1'b0);

    // presses 21 edges apart: two singles; second press lands while pulse high
    tick(1'b0, 1'b1);
    idle_check("bnd21_first", 20, 20, 3'b100);
    chk_state("bnd21_mid", 2'd0, 1'b0, 2'd1, 1'b0);
    tick(1'b0, 1'b1);
    chk("bnd21_pulse_one_cycle", {31'd0, click_single}, 32'd0);
    chk_state("bnd21_reopen", 2'd1, 1'b1, 2'd1, 1'b0);
    idle_check("bnd21_second", 25, 20, 3'b100);
    chk_state("bnd21_done", 2'd0, 1'b0, 2'd2, 1'b0);

    // arm again so the triple has something to clear
    tick(1'b0, 1'b1);
    idle_check("arm_gap", 2, 0, 3'b000);
    tick(1'b0, 1'b1);
    idle_check("arm_evt", 25, 20, 3'b010);
    chk_state("arm_done", 2'd0, 1'b0, 2'd2, 1'b1);

    // saturation: 5 presses 3 cycles apart, one triple
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b1);
      chk_state("sat_cnt", (k >= 2) ? 2'd3 : 2'(k + 1), 1'b1, 2'd2, 1'b1);
      if (k < 4) idle_check("sat_gap", 2, 0, 3'b000);
    end
    idle_check("sat_evt", 25, 20, 3'b001);
    chk_state("sat_done", 2'd0, 1'b0, 2'd0, 1'b0);

    // set mode and armed non-zero before the mid-window reset
    tick(1'b0, 1'b1);
    idle_check("pre_single", 25, 20, 3'b100);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    idle_check("pre_double", 25, 20, 3'b010);
    chk_state("pre_state", 2'd0, 1'b0, 2'd1, 1'b1);

    // mid-window reset: 2 presses, reset 10 cycles later, no event
    tick(1'b0, 1'b1);
    idle_check("mid_gap", 4, 0, 3'b000);
    tick(1'b0, 1'b1);
    idle_check("mid_wait", 10, 0, 3'b000);
    tick(1'b1, 1'b0);
    chk("mid_rst_pulses", {29'd0, click_single, click_double, click_triple}, 32'd0);
    chk_state("mid_rst_state", 2'd0, 1'b0, 2'd0, 1'b0);
    idle_check("mid_no_evt", 40, 0, 3'b000);
    tick(1'b0, 1'b1);
    idle_check("post_single", 25, 20, 3'b100);
    chk_state("post_done", 2'd0, 1'b0, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_click_decoder.md
# btn_click_decoder

Consumes the single-cycle `btn_flag` pulses produced by the debounce stage and classifies them into single, double and triple clicks, using a configurable inter-click window. It sits directly downstream of the debounce block in the logic analyzer's front-panel path. It owns the user-visible capture-mode selector and the arm flag that the capture controller reads.

## Interface
- `WIN_MAX`, 24'd9_999_999: inter-click window length minus one, in clock cycles. The default is 200 ms at 50 MHz; benches use 19.
- `MODE_NUM`, 4: number of capture modes. Legal range 2..4.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_flag`  in  1  debounced press pulse, one cycle wide, synchronous to `clk`.
- `click_single`  out  1  one-cycle pulse: window closed after exactly 1 press.
- `click_double`  out  1  one-cycle pulse: window closed after exactly 2 presses.
- `click_triple`  out  1  one-cycle pulse: window closed after 3 or more presses.
- `click_cnt`  out  2  presses counted in the current open window (0..3, saturating).
- `busy`  out  1  high while a window is open (state != IDLE).
- `mode`  out  2  current capture mode, 0..MODE_NUM-1.
- `armed`  out  1  capture arm flag.

## Operation
- FSM states: IDLE, C1, C2, C3. All outputs are registered.
- IDLE + `btn_flag` → C1. Window counter cleared to 0.
- C1 + `btn_flag` → C2; C2 + `btn_flag` → C3; C3 + `btn_flag` → C3 (saturate). Every accepted pulse clears the window counter to 0.
- In C1/C2/C3 with no `btn_flag`, the window counter increments by 1 per cycle.
- When the counter equals `WIN_MAX` and `btn_flag` is low:
  - emit the event for the current state: C1→`click_single`, C2→`click_double`, C3→`click_triple`;
  - return to IDLE and clear the counter.
- Simultaneous `btn_flag` and counter == `WIN_MAX`: the press wins. It is counted, the window restarts, and no event is emitted.
- `click_cnt` = 0/1/2/3 for IDLE/C1/C2/C3. `busy` = (state != IDLE).
- Action on each event, applied on the same edge that raises the event pulse:
  - single: `mode` ← (`mode` == MODE_NUM-1) ? 0 : `mode`+1.
  - double: `armed` ← ~`armed`.
  - triple: `mode` ← 0, `armed` ← 0.
- At most one event pulse is high in any cycle. Event pulses never assert in consecutive cycles.
- Window counter is 24 bits and never wraps: it is held at `WIN_MAX` for at most one cycle before clearing.
- Reset (`rst` high at a clock edge), including mid-window:
  - state IDLE, counter 0;
  - all event pulses 0, `click_cnt` 0, `busy` 0, `mode` 0, `armed` 0;
  - a `btn_flag` in the same cycle as `rst` is ignored;
  - a partially counted window is discarded with no event.

## Timing
- Let `btn_flag` be sampled high at edge t.
  - `busy` and `click_cnt` update at edge t (visible in the following cycle).
- Let the last press of a burst be sampled at edge t.
  - The counter reaches `WIN_MAX` at edge t+WIN_MAX.
  - The event pulse is high for exactly one cycle after edge t+WIN_MAX+1. `mode`/`armed` update at that same edge, and `busy` falls at that edge.
- Two presses are in the same burst iff their sampling edges are ≤ WIN_MAX+1 cycles apart. Exactly WIN_MAX+1 apart counts as the same burst (press wins).
- A press arriving in the cycle the event pulse is high starts a new window (IDLE→C1). The event still completes.
- Throughput: one `btn_flag` per cycle accepted; the block never stalls.

## Test plan
All scenarios use `WIN_MAX`=19.
- Reset check: hold `rst` high 3 cycles while pulsing `btn_flag` → all outputs 0, `busy` 0; after release, no event within 30 cycles.
- Single click: one `btn_flag` at edge t → `click_cnt`=1, `busy`=1; `click_single` high exactly one cycle after edge t+20; `mode` 0→1; `armed` unchanged.
- Mode wrap: 4 single clicks spaced 40 cycles apart → `mode` goes 1, 2, 3, 0. Then a double click (pulses 5 cycles apart) → `click_double` at 20 cycles after the second press, `armed`=1.
- Window boundary: two presses exactly 20 edges apart → single burst, `click_double`. Two presses 21 edges apart → two `click_single` events, the first 20 cycles after the first press.
- Saturation: 5 presses 3 cycles apart → `click_cnt` stays 3; one `click_triple` 20 cycles after the 5th press; `mode`=0, `armed`=0.
- Mid-window reset: 2 presses, then `rst` 10 cycles later → no event ever emitted; `mode`/`armed`=0; the next single press yields a normal `click_single`.
